// File: rtl/requantize_stage.sv
// rtl/requantize_stage.sv - two-stage accumulator requantizer (scale, round, zero point, saturate)
module requantize_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_load,
  input  logic [SCALE_WIDTH-1:0] cfg_scale,
  input  logic [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic [7:0]             cfg_zero_point,
  output logic                   cfg_busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_value,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_value,
  output logic                   out_last,
  output logic [CNT_WIDTH-1:0]   sat_count,
  input  logic                   sat_clear
);

  localparam int PW = DATA_WIDTH + SCALE_WIDTH;
  localparam int QW = PW + 1;

  logic [SCALE_WIDTH-1:0] scale_r;
  logic [SHIFT_WIDTH-1:0] shift_r;
  logic [7:0]             zp_r;

  logic          s1_valid;
  logic          s1_last;
  logic [PW-1:0] s1_prod;
  logic          s2_sat;

  logic          s2_adv;
  logic          s1_adv;
  logic          cfg_accept;
  logic          in_fire;
  logic          out_fire;
  logic [PW-1:0] prod_next;
  logic [QW-1:0] rnd;
  logic [QW-1:0] q;
  logic [QW-1:0] sum;
  logic          sat_next;

  // out_valid doubles as the stage-2 valid flag.
  assign s2_adv     = !out_valid | out_ready;
  assign s1_adv     = !s1_valid | s2_adv;
  assign cfg_busy   = s1_valid | out_valid;
  assign cfg_accept = cfg_load & !cfg_busy;
  assign in_ready   = s1_adv & !cfg_accept;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;

  always_comb begin
    prod_next = {{SCALE_WIDTH{1'b0}}, in_value} * {{DATA_WIDTH{1'b0}}, scale_r};
    rnd = '0;
    if (shift_r != '0) rnd = QW'(1) << (shift_r - SHIFT_WIDTH'(1));
    q        = ({1'b0, s1_prod} + rnd) >> shift_r;
    sum      = q + QW'(zp_r);
    sat_next = |sum[QW-1:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_r <= SCALE_WIDTH'(1);
      shift_r <= '0;
      zp_r    <= '0;
    end else if (cfg_accept) begin
      scale_r <= cfg_scale;
      shift_r <= cfg_shift;
      zp_r    <= cfg_zero_point;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_prod <= prod_next;
        s1_last <= in_last;
      end
    end
  end

  // Stage 2 refills whenever it is empty, so bubbles collapse under output stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_last  <= 1'b0;
      s2_sat    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_value <= sat_next ? 8'hff : sum[7:0];
        out_last  <= s1_last;
        s2_sat    <= sat_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (out_fire && s2_sat && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_WIDTH'(1);
    end
  end

endmodule
